// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined main-control unit: opcode and ALUop
// encodings, forwarding-select codes and the per-stage control bundles.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_AND   = 2'b11;

    // Operand source for the EX-stage ALU inputs.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Full decoded bundle, held in ID/EX.
    typedef struct packed {
        logic       reg_dst;
        logic       alu_src;
        logic [1:0] alu_op;
        logic       branch;
        logic       bne;
        logic       jump;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_write;
    } ctrl_t;

    // Controls still needed once an instruction leaves EX.
    typedef struct packed {
        logic branch;
        logic bne;
        logic jump;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic reg_write;
    } mem_ctrl_t;

    // Controls still needed in WB.
    typedef struct packed {
        logic mem_to_reg;
        logic reg_write;
    } wb_ctrl_t;

    localparam ctrl_t     CTRL_NOP     = '0;
    localparam mem_ctrl_t MEM_CTRL_NOP = '0;
    localparam wb_ctrl_t  WB_CTRL_NOP  = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_unit.sv
// Load-use stall detection and EX-stage forwarding selects. Purely
// combinational; register 0 never counts as a hazard or forwarding source.
module hazard_unit
    import ctrl_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic             ex_mem_read_i,
    input  logic [REG_W-1:0] ex_rs_i,
    input  logic [REG_W-1:0] ex_rt_i,
    input  logic [REG_W-1:0] id_rs_i,
    input  logic [REG_W-1:0] id_rt_i,
    input  logic             mem_reg_write_i,
    input  logic [REG_W-1:0] mem_dst_i,
    input  logic             wb_reg_write_i,
    input  logic [REG_W-1:0] wb_dst_i,
    output logic             stall_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o
);

    logic mem_src_ok;
    logic wb_src_ok;

    assign mem_src_ok = mem_reg_write_i && (mem_dst_i != '0);
    assign wb_src_ok  = wb_reg_write_i && (wb_dst_i != '0);

    // A load in EX whose target is read by the instruction in ID must wait one cycle.
    always_comb begin
        stall_o = 1'b0;
        if (ex_mem_read_i && (ex_rt_i != '0) &&
            ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i))) begin
            stall_o = 1'b1;
        end
    end

    // Operand A source; the younger EX/MEM result wins over MEM/WB.
    always_comb begin
        fwd_a_o = FWD_RF;
        if (mem_src_ok && (mem_dst_i == ex_rs_i)) begin
            fwd_a_o = FWD_MEM;
        end else if (wb_src_ok && (wb_dst_i == ex_rs_i)) begin
            fwd_a_o = FWD_WB;
        end
    end

    // Operand B source; same priority as operand A.
    always_comb begin
        fwd_b_o = FWD_RF;
        if (mem_src_ok && (mem_dst_i == ex_rt_i)) begin
            fwd_b_o = FWD_MEM;
        end else if (wb_src_ok && (wb_dst_i == ex_rt_i)) begin
            fwd_b_o = FWD_WB;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// Pipelined main control for the 5-stage MIPS core: ID decode, ID/EX, EX/MEM
// and MEM/WB control registers, load-use stall, flush bubbles and forwarding.
// Optional build macro STALL_CNT_EN adds a saturating stall-cycle counter
// (stall_cnt port and CNT_W parameter exist only when it is defined).
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int REG_W    = 5,
    parameter int ALUOP_W  = 2
`ifdef STALL_CNT_EN
    ,
    parameter int CNT_W    = 16
`endif
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPCODE_W-1:0] id_opcode,
    input  logic [REG_W-1:0]    id_rs,
    input  logic [REG_W-1:0]    id_rt,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                flush,
    output logic                pc_write,
    output logic                if_id_write,
    output logic                id_illegal,
    output logic                ex_reg_dst,
    output logic                ex_alu_src,
    output logic [ALUOP_W-1:0]  ex_alu_op,
    output logic [REG_W-1:0]    ex_dst,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic                mem_read,
    output logic                mem_write,
    output logic                mem_branch,
    output logic                mem_bne,
    output logic                mem_jump,
    output logic [REG_W-1:0]    mem_dst,
    output logic                wb_reg_write,
    output logic                wb_mem_to_reg,
    output logic [REG_W-1:0]    wb_dst
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]    stall_cnt
`endif
);

    ctrl_t            id_ctrl;
    logic             stall;

    ctrl_t            idex_ctrl_q,  idex_ctrl_d;
    logic [REG_W-1:0] idex_rs_q,    idex_rs_d;
    logic [REG_W-1:0] idex_rt_q,    idex_rt_d;
    logic [REG_W-1:0] idex_rd_q,    idex_rd_d;

    mem_ctrl_t        exmem_ctrl_q, exmem_ctrl_d;
    logic [REG_W-1:0] exmem_dst_q,  exmem_dst_d;

    wb_ctrl_t         memwb_ctrl_q, memwb_ctrl_d;
    logic [REG_W-1:0] memwb_dst_q,  memwb_dst_d;

    logic [REG_W-1:0] ex_dst_w;

    // Opcode decode; anything outside the table decodes to a bubble and flags illegal.
    always_comb begin
        id_ctrl    = CTRL_NOP;
        id_illegal = 1'b0;
        case (id_opcode)
            OPCODE_W'(OP_RTYPE): begin
                id_ctrl.reg_dst   = 1'b1;
                id_ctrl.alu_op    = ALUOP_FUNCT;
                id_ctrl.reg_write = 1'b1;
            end
            OPCODE_W'(OP_ADDI): begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_ADD;
                id_ctrl.reg_write = 1'b1;
            end
            OPCODE_W'(OP_ANDI): begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_AND;
                id_ctrl.reg_write = 1'b1;
            end
            OPCODE_W'(OP_BEQ): begin
                id_ctrl.branch = 1'b1;
                id_ctrl.alu_op = ALUOP_SUB;
            end
            OPCODE_W'(OP_BNE): begin
                id_ctrl.bne    = 1'b1;
                id_ctrl.alu_op = ALUOP_SUB;
            end
            OPCODE_W'(OP_J): begin
                id_ctrl.jump = 1'b1;
            end
            OPCODE_W'(OP_LW): begin
                id_ctrl.alu_src    = 1'b1;
                id_ctrl.alu_op     = ALUOP_ADD;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.reg_write  = 1'b1;
            end
            OPCODE_W'(OP_SW): begin
                id_ctrl.alu_src   = 1'b1;
                id_ctrl.alu_op    = ALUOP_ADD;
                id_ctrl.mem_write = 1'b1;
            end
            default: begin
                id_illegal = 1'b1;
            end
        endcase
    end

    hazard_unit #(
        .REG_W(REG_W)
    ) u_hazard (
        .ex_mem_read_i   (idex_ctrl_q.mem_read),
        .ex_rs_i         (idex_rs_q),
        .ex_rt_i         (idex_rt_q),
        .id_rs_i         (id_rs),
        .id_rt_i         (id_rt),
        .mem_reg_write_i (exmem_ctrl_q.reg_write),
        .mem_dst_i       (exmem_dst_q),
        .wb_reg_write_i  (memwb_ctrl_q.reg_write),
        .wb_dst_i        (memwb_dst_q),
        .stall_o         (stall),
        .fwd_a_o         (fwd_a),
        .fwd_b_o         (fwd_b)
    );

    // A flush overrides the stall so the front end keeps fetching from the new target.
    assign pc_write    = flush | ~stall;
    assign if_id_write = flush | ~stall;

    assign ex_dst_w = idex_ctrl_q.reg_dst ? idex_rd_q : idex_rt_q;

    // ID/EX next value: bubble on flush or load-use stall, otherwise the decoded ID instruction.
    always_comb begin
        idex_ctrl_d = CTRL_NOP;
        idex_rs_d   = '0;
        idex_rt_d   = '0;
        idex_rd_d   = '0;
        if (!flush && !stall) begin
            idex_ctrl_d = id_ctrl;
            idex_rs_d   = id_rs;
            idex_rt_d   = id_rt;
            idex_rd_d   = id_rd;
        end
    end

    // EX/MEM next value: bubble on flush, otherwise the EX instruction's remaining controls.
    always_comb begin
        exmem_ctrl_d = MEM_CTRL_NOP;
        exmem_dst_d  = '0;
        if (!flush) begin
            exmem_ctrl_d.branch     = idex_ctrl_q.branch;
            exmem_ctrl_d.bne        = idex_ctrl_q.bne;
            exmem_ctrl_d.jump       = idex_ctrl_q.jump;
            exmem_ctrl_d.mem_read   = idex_ctrl_q.mem_read;
            exmem_ctrl_d.mem_write  = idex_ctrl_q.mem_write;
            exmem_ctrl_d.mem_to_reg = idex_ctrl_q.mem_to_reg;
            exmem_ctrl_d.reg_write  = idex_ctrl_q.reg_write;
            exmem_dst_d             = ex_dst_w;
        end
    end

    // MEM/WB next value: always advances, the branch it resolves is older than the flush.
    always_comb begin
        memwb_ctrl_d            = WB_CTRL_NOP;
        memwb_ctrl_d.mem_to_reg = exmem_ctrl_q.mem_to_reg;
        memwb_ctrl_d.reg_write  = exmem_ctrl_q.reg_write;
        memwb_dst_d             = exmem_dst_q;
    end

    // Stage registers; reset empties the whole pipe to bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idex_ctrl_q  <= CTRL_NOP;
            idex_rs_q    <= '0;
            idex_rt_q    <= '0;
            idex_rd_q    <= '0;
            exmem_ctrl_q <= MEM_CTRL_NOP;
            exmem_dst_q  <= '0;
            memwb_ctrl_q <= WB_CTRL_NOP;
            memwb_dst_q  <= '0;
        end else begin
            idex_ctrl_q  <= idex_ctrl_d;
            idex_rs_q    <= idex_rs_d;
            idex_rt_q    <= idex_rt_d;
            idex_rd_q    <= idex_rd_d;
            exmem_ctrl_q <= exmem_ctrl_d;
            exmem_dst_q  <= exmem_dst_d;
            memwb_ctrl_q <= memwb_ctrl_d;
            memwb_dst_q  <= memwb_dst_d;
        end
    end

    assign ex_reg_dst    = idex_ctrl_q.reg_dst;
    assign ex_alu_src    = idex_ctrl_q.alu_src;
    assign ex_alu_op     = ALUOP_W'(idex_ctrl_q.alu_op);
    assign ex_dst        = ex_dst_w;
    assign mem_read      = exmem_ctrl_q.mem_read;
    assign mem_write     = exmem_ctrl_q.mem_write;
    assign mem_branch    = exmem_ctrl_q.branch;
    assign mem_bne       = exmem_ctrl_q.bne;
    assign mem_jump      = exmem_ctrl_q.jump;
    assign mem_dst       = exmem_dst_q;
    assign wb_reg_write  = memwb_ctrl_q.reg_write;
    assign wb_mem_to_reg = memwb_ctrl_q.mem_to_reg;
    assign wb_dst        = memwb_dst_q;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count genuine stall cycles only; a flushed stall inserts no extra bubble.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !flush && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule
